// File: rtl/frame_data_writer_if.sv
// ============================================================================
// Module  : frame_data_writer_if
// Brief   : Valid/ready word stream into the frame data writer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface frame_data_writer_if #(
    parameter int FrameBitsPerRow = 32
);
    logic [FrameBitsPerRow-1:0] s_data;
    logic                       s_valid;
    logic                       s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

`default_nettype wire

// File: rtl/frame_data_writer.sv
// ============================================================================
// Module  : frame_data_writer
// Brief   : Parses a header, broadcasts N frame words row by row, then pulses
//           the column frame strobe for the addressed frame.
// Revision: 1.0
// ============================================================================
`default_nettype none

module frame_data_writer #(
    parameter int FrameBitsPerRow = 32,
    parameter int RowSelectWidth  = 5,
    parameter int NumberOfRows    = 16,
    parameter int MaxFramesPerCol = 20
) (
    input  wire logic                       CLK,
    input  wire logic                       resetn,
    frame_data_writer_if.slave              s_if,
    input  wire logic                       clr_err,
    output      logic [FrameBitsPerRow-1:0] FrameData_O,
    output      logic [RowSelectWidth-1:0]  RowSelect_O,
    output      logic [MaxFramesPerCol-1:0] FrameStrobe_O,
    output      logic                       busy,
    output      logic                       err
);

    localparam logic [7:0] c_SYNC    = 8'hFA;
    localparam logic [8:0] c_MAX_ROW = 9'(NumberOfRows);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_STROBE = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [7:0]                  frame_q, frame_d;
    logic [7:0]                  nrows_q, nrows_d;
    logic [7:0]                  row_q,   row_d;
    logic [7:0]                  cnt_q,   cnt_d;
    logic [FrameBitsPerRow-1:0]  fdata_q, fdata_d;
    logic [RowSelectWidth-1:0]   rsel_q,  rsel_d;
    logic [MaxFramesPerCol-1:0]  fstrb_q, fstrb_d;
    logic                        err_q,   err_d;

    logic       w_ready;
    logic       w_accept;
    logic [7:0] w_sync;
    logic [7:0] w_frame;
    logic [7:0] w_nrows;
    logic [7:0] w_start;
    logic [8:0] w_end_row;
    logic       w_hdr_ok;

    // Ready is gated by resetn so nothing is taken while reset is held.
    assign w_ready  = resetn && ((state_q == ST_IDLE) || (state_q == ST_DATA));
    assign w_accept = s_if.s_valid && w_ready;

    assign w_sync  = s_if.s_data[31:24];
    assign w_frame = s_if.s_data[23:16];
    assign w_nrows = s_if.s_data[15:8];
    assign w_start = s_if.s_data[7:0];

    // Nine bits so a large start row plus row count cannot wrap into range.
    assign w_end_row = {1'b0, w_start} + {1'b0, w_nrows} - 9'd1;

    assign w_hdr_ok = (w_sync == c_SYNC)
                   && (int'(w_frame) < MaxFramesPerCol)
                   && (w_nrows != 8'd0)
                   && (w_start != 8'd0)
                   && (w_end_row <= c_MAX_ROW);

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        nrows_d = nrows_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        fdata_d = fdata_q;
        rsel_d  = '0;
        fstrb_d = '0;
        err_d   = clr_err ? 1'b0 : err_q;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_hdr_ok) begin
                        frame_d = w_frame;
                        nrows_d = w_nrows;
                        row_d   = w_start;
                        cnt_d   = 8'd0;
                        state_d = ST_DATA;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (w_accept) begin
                    fdata_d = s_if.s_data;
                    rsel_d  = row_q[RowSelectWidth-1:0];
                    row_d   = row_q + 8'd1;
                    cnt_d   = cnt_q + 8'd1;
                    if ((cnt_q + 8'd1) == nrows_q) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                // Registered here so the pulse lines up with the STROBE state.
                fstrb_d = {{(MaxFramesPerCol-1){1'b0}}, 1'b1} << frame_q;
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            nrows_q <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            fdata_q <= '0;
            rsel_q  <= '0;
            fstrb_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            nrows_q <= nrows_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            fdata_q <= fdata_d;
            rsel_q  <= rsel_d;
            fstrb_q <= fstrb_d;
            err_q   <= err_d;
        end
    end

    assign s_if.s_ready  = w_ready;
    assign FrameData_O   = fdata_q;
    assign RowSelect_O   = rsel_q;
    assign FrameStrobe_O = fstrb_q;
    assign busy          = (state_q != ST_IDLE);
    assign err           = err_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_data_writer.sv
// ============================================================================
// Module  : tb_frame_data_writer
// Brief   : Directed vector table plus gap and mid-frame reset sequences.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_frame_data_writer;

    logic        CLK;
    logic        resetn;
    logic        clr_err;
    logic [31:0] FrameData_O;
    logic [4:0]  RowSelect_O;
    logic [19:0] FrameStrobe_O;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    frame_data_writer_if #(.FrameBitsPerRow(32)) sif ();

    frame_data_writer #(
        .FrameBitsPerRow (32),
        .RowSelectWidth  (5),
        .NumberOfRows    (16),
        .MaxFramesPerCol (20)
    ) dut (
        .CLK           (CLK),
        .resetn        (resetn),
        .s_if          (sif),
        .clr_err       (clr_err),
        .FrameData_O   (FrameData_O),
        .RowSelect_O   (RowSelect_O),
        .FrameStrobe_O (FrameStrobe_O),
        .busy          (busy),
        .err           (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] d;
        logic        v;
        logic        clr;
        logic        rdy;
        logic [4:0]  rs;
        logic [31:0] fd;
        logic [19:0] fs;
        logic        bsy;
        logic        er;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [31:0] d, input logic v, input logic c);
        @(negedge CLK);
        sif.s_data  = d;
        sif.s_valid = v;
        clr_err     = c;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all(input string p, input logic rdy, input logic [4:0] rs,
                           input logic [31:0] fd, input logic [19:0] fs,
                           input logic bsy, input logic er);
        chk({p, "_ready"}, 32'(sif.s_ready), 32'(rdy));
        chk({p, "_rowsel"}, 32'(RowSelect_O), 32'(rs));
        chk({p, "_fdata"}, FrameData_O, fd);
        chk({p, "_strobe"}, 32'(FrameStrobe_O), 32'(fs));
        chk({p, "_busy"}, 32'(busy), 32'(bsy));
        chk({p, "_err"}, 32'(err), 32'(er));
    endtask

    initial begin
        int pulses;
        logic [19:0] last_fs;

        //             d             v     clr   rdy   rs     fd            fs         bsy   er
        vecs.push_back('{32'hFA030201, 1'b1, 1'b0, 1'b1, 5'd0,  32'h00000000, 20'h00000, 1'b1, 1'b0});
        vecs.push_back('{32'h11111111, 1'b1, 1'b0, 1'b1, 5'd1,  32'h11111111, 20'h00000, 1'b1, 1'b0});
        vecs.push_back('{32'h22222222, 1'b1, 1'b0, 1'b0, 5'd2,  32'h22222222, 20'h00000, 1'b1, 1'b0});
        vecs.push_back('{32'h33333333, 1'b1, 1'b0, 1'b0, 5'd0,  32'h22222222, 20'h00008, 1'b1, 1'b0});
        vecs.push_back('{32'h00000000, 1'b0, 1'b0, 1'b1, 5'd0,  32'h22222222, 20'h00000, 1'b0, 1'b0});
        vecs.push_back('{32'hFB000101, 1'b1, 1'b0, 1'b1, 5'd0,  32'h22222222, 20'h00000, 1'b0, 1'b1});
        vecs.push_back('{32'h00000000, 1'b0, 1'b1, 1'b1, 5'd0,  32'h22222222, 20'h00000, 1'b0, 1'b0});
        vecs.push_back('{32'hFA140101, 1'b1, 1'b0, 1'b1, 5'd0,  32'h22222222, 20'h00000, 1'b0, 1'b1});
        vecs.push_back('{32'h00000000, 1'b0, 1'b1, 1'b1, 5'd0,  32'h22222222, 20'h00000, 1'b0, 1'b0});
        vecs.push_back('{32'hFA000010, 1'b1, 1'b0, 1'b1, 5'd0,  32'h22222222, 20'h00000, 1'b0, 1'b1});
        vecs.push_back('{32'h00000000, 1'b0, 1'b1, 1'b1, 5'd0,  32'h22222222, 20'h00000, 1'b0, 1'b0});
        vecs.push_back('{32'hFA000310, 1'b1, 1'b0, 1'b1, 5'd0,  32'h22222222, 20'h00000, 1'b0, 1'b1});
        vecs.push_back('{32'h00000000, 1'b0, 1'b1, 1'b1, 5'd0,  32'h22222222, 20'h00000, 1'b0, 1'b0});
        vecs.push_back('{32'hFA00020F, 1'b1, 1'b0, 1'b1, 5'd0,  32'h22222222, 20'h00000, 1'b1, 1'b0});
        vecs.push_back('{32'hAAAAAAAA, 1'b1, 1'b0, 1'b1, 5'd15, 32'hAAAAAAAA, 20'h00000, 1'b1, 1'b0});
        vecs.push_back('{32'hBBBBBBBB, 1'b1, 1'b0, 1'b0, 5'd16, 32'hBBBBBBBB, 20'h00000, 1'b1, 1'b0});
        vecs.push_back('{32'h00000000, 1'b0, 1'b0, 1'b0, 5'd0,  32'hBBBBBBBB, 20'h00001, 1'b1, 1'b0});
        vecs.push_back('{32'h00000000, 1'b0, 1'b0, 1'b1, 5'd0,  32'hBBBBBBBB, 20'h00000, 1'b0, 1'b0});
        vecs.push_back('{32'hFB000000, 1'b1, 1'b0, 1'b1, 5'd0,  32'hBBBBBBBB, 20'h00000, 1'b0, 1'b1});
        vecs.push_back('{32'hFB000000, 1'b1, 1'b1, 1'b1, 5'd0,  32'hBBBBBBBB, 20'h00000, 1'b0, 1'b1});
        vecs.push_back('{32'h00000000, 1'b0, 1'b1, 1'b1, 5'd0,  32'hBBBBBBBB, 20'h00000, 1'b0, 1'b0});
        vecs.push_back('{32'hFA130101, 1'b1, 1'b0, 1'b1, 5'd0,  32'hBBBBBBBB, 20'h00000, 1'b1, 1'b0});
        vecs.push_back('{32'h00000005, 1'b1, 1'b0, 1'b0, 5'd1,  32'h00000005, 20'h00000, 1'b1, 1'b0});
        vecs.push_back('{32'h00000000, 1'b0, 1'b0, 1'b0, 5'd0,  32'h00000005, 20'h80000, 1'b1, 1'b0});
        vecs.push_back('{32'h00000000, 1'b0, 1'b0, 1'b1, 5'd0,  32'h00000005, 20'h00000, 1'b0, 1'b0});

        resetn      = 1'b0;
        clr_err     = 1'b0;
        sif.s_data  = '0;
        sif.s_valid = 1'b0;
        #12;
        chk_all("reset", 1'b0, 5'd0, 32'h0, 20'h0, 1'b0, 1'b0);
        @(negedge CLK);
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].d, vecs[i].v, vecs[i].clr);
            chk_all($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].rs, vecs[i].fd,
                    vecs[i].fs, vecs[i].bsy, vecs[i].er);
        end

        // 16-row frame with a 3-cycle valid gap after word 5.
        step(32'hFA001001, 1'b1, 1'b0);
        chk("gap_hdr_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            step(32'(k) * 32'h01010101, 1'b1, 1'b0);
            chk($sformatf("gap_rs%0d", k), 32'(RowSelect_O), 32'(k));
            chk($sformatf("gap_fd%0d", k), FrameData_O, 32'(k) * 32'h01010101);
            if (k == 5) begin
                for (int g = 0; g < 3; g++) begin
                    step(32'hDEADBEEF, 1'b0, 1'b0);
                    chk($sformatf("gap_hold_rs%0d", g), 32'(RowSelect_O), 32'd0);
                    chk($sformatf("gap_hold_busy%0d", g), 32'(busy), 32'd1);
                    chk($sformatf("gap_hold_rdy%0d", g), 32'(sif.s_ready), 32'd1);
                end
            end
        end
        pulses  = 0;
        last_fs = '0;
        for (int c = 0; c < 4; c++) begin
            step(32'h0, 1'b0, 1'b0);
            if (FrameStrobe_O != '0) begin
                pulses++;
                last_fs = FrameStrobe_O;
            end
        end
        chk("gap_strobe_count", 32'(pulses), 32'd1);
        chk("gap_strobe_value", 32'(last_fs), 32'h1);
        chk("gap_end_busy", 32'(busy), 32'd0);

        // Reset in the middle of a 4-word frame, with err already set.
        step(32'hFB000000, 1'b1, 1'b0);
        chk("rst_pre_err", 32'(err), 32'd1);
        step(32'hFA050401, 1'b1, 1'b0);
        step(32'h0000AAAA, 1'b1, 1'b0);
        step(32'h0000BBBB, 1'b1, 1'b0);
        chk("rst_pre_rs", 32'(RowSelect_O), 32'd2);
        @(negedge CLK);
        sif.s_valid = 1'b0;
        resetn      = 1'b0;
        #1;
        chk_all("rst_async", 1'b0, 5'd0, 32'h0, 20'h0, 1'b0, 1'b0);
        @(negedge CLK);
        resetn = 1'b1;
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            step(32'h0, 1'b0, 1'b0);
            if (FrameStrobe_O != '0) pulses++;
        end
        chk("rst_no_strobe", 32'(pulses), 32'd0);
        step(32'hFA000101, 1'b1, 1'b0);
        chk("rst_hdr_busy", 32'(busy), 32'd1);
        chk("rst_hdr_err", 32'(err), 32'd0);
        step(32'h00000077, 1'b1, 1'b0);
        chk("rst_data_rs", 32'(RowSelect_O), 32'd1);
        chk("rst_data_fd", FrameData_O, 32'h00000077);
        step(32'h0, 1'b0, 1'b0);
        chk("rst_strobe", 32'(FrameStrobe_O), 32'h1);
        step(32'h0, 1'b0, 1'b0);
        chk("rst_end_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/frame_data_writer.md
FRAME_DATA_WRITER -- requirements
Module: frame_data_writer

Interface
REQ-001 SHALL have parameter FrameBitsPerRow, default 32, width of frame data words and of the input stream.
REQ-002 SHALL have parameter RowSelectWidth, default 5, width of RowSelect_O.
REQ-003 SHALL have parameter NumberOfRows, default 16, highest addressable row; rows are numbered 1..NumberOfRows.
REQ-004 SHALL have parameter MaxFramesPerCol, default 20, width of FrameStrobe_O.
REQ-005 SHALL have the following ports:
- CLK  input  1  clock, all state updates on its rising edge.
- resetn  input  1  reset, asynchronous and active-low.
- s_data  input  FrameBitsPerRow  stream word (header or frame data).
- s_valid  input  1  s_data valid.
- s_ready  output  1  writer accepts s_data this cycle.
- clr_err  input  1  clears err.
- FrameData_O  output  FrameBitsPerRow  frame data broadcast to row registers.
- RowSelect_O  output  RowSelectWidth  target row; 0 means no row selected.
- FrameStrobe_O  output  MaxFramesPerCol  one-hot column frame strobe.
- busy  output  1  high whenever the state is not IDLE.
- err  output  1  sticky malformed-header flag.

Function
REQ-006 SHALL transfer a word only on a rising edge where s_valid and s_ready are both 1.
REQ-007 SHALL implement the states IDLE, DATA, FLUSH and STROBE.
REQ-008 SHALL hold s_ready at 1 in IDLE and DATA, and at 0 in FLUSH and STROBE.
REQ-009 SHALL interpret a word accepted in IDLE as a header with the following fields:
- bits[31:24] sync, which must equal 0xFA.
- bits[23:16] frame index F.
- bits[15:8] row count N.
- bits[7:0] start row S.
REQ-010 SHALL treat a header as valid only if all of the following hold: sync is 0xFA, F < MaxFramesPerCol, N >= 1, S >= 1, and S+N-1 <= NumberOfRows, with S+N-1 computed at 9-bit width so it cannot wrap.
REQ-011 SHALL, on a valid header, latch F, N and S, set the row counter to S, and enter DATA.
REQ-012 SHALL, on an invalid header, set err to 1, stay in IDLE, and produce no RowSelect_O or FrameStrobe_O activity.
REQ-013 SHALL, on each word accepted in DATA, drive FrameData_O with that word and RowSelect_O with the current row in the next cycle, then increment the row counter.
REQ-014 SHALL return RowSelect_O to 0 in every cycle not immediately following a DATA accept; RowSelect_O is therefore nonzero for exactly one cycle per data word.
REQ-015 SHALL hold FrameData_O at its last value when RowSelect_O is 0.
REQ-016 SHALL enter FLUSH after accepting the N-th data word, and SHALL enter STROBE one cycle later.
REQ-017 SHALL, in STROBE, drive FrameStrobe_O with only bit F set for exactly one cycle, then enter IDLE.
REQ-018 SHALL tolerate s_valid gaps in DATA without timeout; the state and the row counter hold.
REQ-019 SHALL, when clr_err is 1, clear err on that edge; if an invalid header is accepted in the same cycle, err SHALL be set (set wins).
REQ-020 SHALL give the minimum end-to-end timing as follows:
- Header accepted at cycle t.
- First data word accepted at t+1.
- Last data word accepted at t+N.
- RowSelect_O pulse for the last row at t+N+1 (FLUSH).
- FrameStrobe_O pulse at t+N+2 (STROBE).
- Next header accepted at t+N+3.

Reset
REQ-021 SHALL, while resetn is 0, force state to IDLE and all of the following to 0: FrameData_O, RowSelect_O, FrameStrobe_O, busy, err, and all internal counters and latched fields.
REQ-022 SHALL, on reset asserted mid-frame (any state), abort the frame with no FrameStrobe_O pulse, and accept the next word after release as a header.
REQ-023 SHALL drive s_ready at 0 while resetn is 0.

Verification
REQ-024 SHALL pass this directed scenario: header 0xFA03_0201 then data 0x1111_1111 and 0x2222_2222 with s_valid held high. Required response:
- RowSelect_O=1 with FrameData_O=0x11111111.
- Next cycle, RowSelect_O=2 with FrameData_O=0x22222222.
- Next cycle, RowSelect_O=0.
- Next cycle, FrameStrobe_O=0x00008 for one cycle.
- busy falls the following cycle.
REQ-025 SHALL pass this directed scenario: header 0xFA00_1001 with 16 data words, and s_valid dropped for 3 cycles after word 5. Required response:
- RowSelect_O steps 1..16 with a 3-cycle RowSelect_O=0 gap after row 5.
- Exactly one FrameStrobe_O=0x00001 pulse.
REQ-026 SHALL pass this directed scenario: headers 0xFB00_0101 (bad sync), 0xFA14_0101 (F=20), 0xFA00_0010 (S=16, N=0) and 0xFA00_020F (S+N-1=16 passes; 0xFA00_0310 fails). Required response:
- err=1 after each invalid header.
- busy stays 0 for the invalid headers.
- Only the valid header starts a frame.
REQ-027 SHALL pass this directed scenario: resetn pulsed low for 1 cycle during DATA after 2 of 4 words. Required response:
- All outputs read 0 immediately (asynchronously).
- No FrameStrobe_O pulse occurs.
- The next word after release is parsed as a header.
REQ-028 SHALL pass this directed scenario: clr_err=1 in the same cycle an invalid header is accepted, with err already 1. Required response:
- err remains 1.
- clr_err alone on the next cycle sets err=0.
